// File: rtl/rgb_led_driver_if.sv
// Purpose: bundles the lamp-level inputs and PWM pin outputs of rgb_led_driver.
// Latency: none (wires only).
// Backpressure: none; levels are sampled every clock, no handshake.
//   master: en, red_in, green_in, blue_in out; led_r, led_g, led_b, busy in
//   slave : the driver side, directions mirrored
interface rgb_led_driver_if;
    logic en;
    logic red_in;
    logic green_in;
    logic blue_in;
    logic led_r;
    logic led_g;
    logic led_b;
    logic busy;

    modport master (
        output en,
        output red_in,
        output green_in,
        output blue_in,
        input  led_r,
        input  led_g,
        input  led_b,
        input  busy
    );

    modport slave (
        input  en,
        input  red_in,
        input  green_in,
        input  blue_in,
        output led_r,
        output led_g,
        output led_b,
        output busy
    );
endinterface

// File: rtl/rgb_led_driver.sv
// Purpose: PWM driver for an RGB LED with linear per-channel fade between 0 and MAX_DUTY.
// Latency: target 1 clk after input, ramp moves on step ticks, PWM pin 1 clk after duty/counter.
// Backpressure: none; inputs are level-sampled every clock and never stalled.
//   ports: clk, rst (async, active-high), bus (slave): en, red_in, green_in, blue_in ->
//          led_r, led_g, led_b (registered PWM pins), busy (any channel still ramping)
module rgb_led_driver #(
    parameter int PWM_BITS  = 8,
    parameter int MAX_DUTY  = 200,
    parameter int STEP_DIV  = 16,
    parameter int RAMP_STEP = 8
) (
    input  logic             clk,
    input  logic             rst,
    rgb_led_driver_if.slave  bus
);

    localparam int NCH   = 3;
    localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    // A step larger than the whole duty range behaves exactly like a full-range
    // step (the result clamps at the target anyway), so clip it to keep the
    // PWM_BITS+1 bit arithmetic free of overflow.
    localparam int STEP_CLIP = (RAMP_STEP > (2 ** PWM_BITS)) ? (2 ** PWM_BITS) : RAMP_STEP;

    localparam logic [PWM_BITS:0]   STEP_W   = (PWM_BITS + 1)'(STEP_CLIP);
    localparam logic [PWM_BITS-1:0] MAX_W    = PWM_BITS'(MAX_DUTY);
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(STEP_DIV - 1);

    // Elaboration-time parameter sanity
    generate
        if (MAX_DUTY > (2 ** PWM_BITS) - 1 || MAX_DUTY < 0) begin : g_bad_max_duty
            $error("rgb_led_driver: MAX_DUTY out of range for PWM_BITS");
        end
        if (STEP_DIV < 1) begin : g_bad_step_div
            $error("rgb_led_driver: STEP_DIV must be >= 1");
        end
        if (RAMP_STEP < 1) begin : g_bad_ramp_step
            $error("rgb_led_driver: RAMP_STEP must be >= 1");
        end
    endgenerate

    // Channel index 0 = red, 1 = green, 2 = blue
    logic [NCH-1:0]               lamp;
    logic [NCH-1:0][PWM_BITS-1:0] tgt;
    logic [NCH-1:0][PWM_BITS-1:0] duty;
    logic [NCH-1:0][PWM_BITS-1:0] duty_nxt;
    logic [NCH-1:0]               led;
    logic [PWM_BITS-1:0]          pwm_cnt;
    logic [DIV_W-1:0]             div_cnt;
    logic                         tick;

    assign lamp = {bus.blue_in, bus.green_in, bus.red_in};

    // One ramp step toward the target, landing exactly on it when closer than
    // one step. The extra top bit keeps duty+step from wrapping.
    function automatic logic [PWM_BITS-1:0] ramp_step(
        input logic [PWM_BITS-1:0] cur,
        input logic [PWM_BITS-1:0] tgt_v
    );
        logic [PWM_BITS:0] c;
        logic [PWM_BITS:0] t;
        logic [PWM_BITS:0] r;
        c = {1'b0, cur};
        t = {1'b0, tgt_v};
        r = c;
        if (c < t) begin
            r = c + STEP_W;
            if (r > t) begin
                r = t;
            end
        end else if (c > t) begin
            if ((c - t) <= STEP_W) begin
                r = t;
            end else begin
                r = c - STEP_W;
            end
        end
        return PWM_BITS'(r);
    endfunction

    assign tick = (div_cnt == DIV_LAST);

    // Ramp always starts from the current duty, so a target flip mid-fade
    // simply reverses direction at the next tick.
    always_comb begin
        duty_nxt = duty;
        if (tick) begin
            for (int c = 0; c < NCH; c++) begin
                duty_nxt[c] = ramp_step(duty[c], tgt[c]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            pwm_cnt <= '0;
            tgt     <= '0;
            duty    <= '0;
            led     <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            // Free-running; all channels share it so equal duties stay in phase.
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            duty    <= duty_nxt;
            for (int c = 0; c < NCH; c++) begin
                tgt[c] <= (bus.en && lamp[c]) ? MAX_W : '0;
                led[c] <= (pwm_cnt < duty[c]);
            end
        end
    end

    assign bus.led_r = led[0];
    assign bus.led_g = led[1];
    assign bus.led_b = led[2];

    // Pure function of registers only, so no input-driven glitches.
    assign bus.busy = (duty[0] != tgt[0]) || (duty[1] != tgt[1]) || (duty[2] != tgt[2]);

endmodule
